dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/mem_defs.sv | 7 +
 rtl/dmem_ctrl_if.sv | 12 +
 rtl/lsu_align.sv | 32 +++
 rtl/dmem_ctrl.sv | 84 ++++++++
 tb/tb_dmem_ctrl.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/mem_defs.sv
// mem_defs: shared access encodings and FSM state constants for the data-memory controller
package mem_defs;
  localparam logic [1:0] WM_NONE = 2'b00, WM_SB = 2'b01, WM_SH = 2'b10, WM_SW = 2'b11;
  localparam logic [2:0] RM_NONE = 3'b000, RM_LB = 3'b001, RM_LBU = 3'b010,
                         RM_LH = 3'b011, RM_LHU = 3'b100, RM_LW = 3'b101;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_DONE = 2'd2;
endpackage

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: word-bus handshake between the data-memory controller and memory
interface dmem_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  modport master(output bus_req, bus_we, bus_addr, bus_be, bus_wdata, input bus_ack, bus_rdata);
  modport slave(input bus_req, bus_we, bus_addr, bus_be, bus_wdata, output bus_ack, bus_rdata);
endinterface

// File: rtl/lsu_align.sv
// lsu_align: store lane steering/byte enables, misalignment check and load extension
module lsu_align
  import mem_defs::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  wm,
  input  logic [2:0]  rm,
  input  logic [31:0] st_data,
  input  logic [1:0]  ld_off,
  input  logic [2:0]  ld_op,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic        misalign
);
  logic [31:0] sh;
  assign be = wm == WM_SB ? 4'b0001 << off :
              wm == WM_SH ? 4'b0011 << off :
              wm == WM_SW ? 4'b1111 : 4'b0000;
  assign wdata = wm == WM_SB ? {4{st_data[7:0]}} :
                 wm == WM_SH ? {2{st_data[15:0]}} :
                 wm == WM_SW ? st_data : 32'h0;
  assign misalign = ((wm == WM_SH || rm == RM_LH || rm == RM_LHU) && off[0]) ||
                    ((wm == WM_SW || rm == RM_LW) && off != 2'b00);
  assign sh = rdata >> {ld_off, 3'b000};
  assign ld_data = ld_op == RM_LB  ? {{24{sh[7]}}, sh[7:0]} :
                   ld_op == RM_LBU ? {24'h0, sh[7:0]} :
                   ld_op == RM_LH  ? {{16{sh[15]}}, sh[15:0]} :
                   ld_op == RM_LHU ? {16'h0, sh[15:0]} :
                   ld_op == RM_LW  ? rdata : 32'h0;
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: MEM-stage data-memory controller (IDLE/WAIT/DONE); DMEM_TIMEOUT_EN enables bus timeout abort
module dmem_ctrl
  import mem_defs::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [1:0]  write_mem,
  input  logic [2:0]  read_mem,
  output logic [31:0] out_mem,
  output logic        mem_stall,
  output logic        misalign,
  output logic        bus_err,
  dmem_ctrl_if.master bus
);
  logic [1:0]  state;
  logic [29:0] addr_q;
  logic [3:0]  be_q, be;
  logic        we_q, start, timeout, wait_s;
  logic [31:0] wdata_q, rdata_q, wdata, ld_data;
  logic [2:0]  op_q, rd_op;
  logic [1:0]  off_q;
  // a store wins over a simultaneous read; encodings 110/111 are no-ops
  assign rd_op  = (write_mem != WM_NONE || read_mem > RM_LW) ? RM_NONE : read_mem;
  assign start  = state == ST_IDLE && (write_mem != WM_NONE || rd_op != RM_NONE) && !misalign;
  assign wait_s = state == ST_WAIT;
  lsu_align u_align (
    .off(address[1:0]), .wm(write_mem), .rm(rd_op), .st_data(write_data),
    .ld_off(off_q), .ld_op(op_q), .rdata(rdata_q),
    .be(be), .wdata(wdata), .ld_data(ld_data), .misalign(misalign)
  );
`ifdef DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic          err_q;
  assign timeout = wait_s && !bus.bus_ack && cnt == CW'(TIMEOUT - 1);
  assign bus_err = err_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      cnt   <= wait_s ? cnt + 1'b1 : '0;
      err_q <= timeout;
    end
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      op_q    <= RM_NONE;
      off_q   <= '0;
      rdata_q <= '0;
    end else begin
      state <= state == ST_IDLE ? (start ? ST_WAIT : ST_IDLE) :
               wait_s ? ((bus.bus_ack || timeout) ? ST_DONE : ST_WAIT) : ST_IDLE;
      if (start) begin
        addr_q  <= address[31:2];
        be_q    <= be;
        we_q    <= write_mem != WM_NONE;
        wdata_q <= wdata;
        op_q    <= rd_op;
        off_q   <= address[1:0];
      end
      if (wait_s && bus.bus_ack) rdata_q <= bus.bus_rdata;
      else if (timeout) rdata_q <= '0;
    end
  assign bus.bus_req   = wait_s;
  assign bus.bus_we    = wait_s && we_q;
  assign bus.bus_addr  = wait_s ? {addr_q, 2'b00} : 32'h0;
  assign bus.bus_be    = wait_s ? be_q : 4'h0;
  assign bus.bus_wdata = wait_s ? wdata_q : 32'h0;
  assign mem_stall     = !rst && (wait_s || start);
  assign out_mem       = state == ST_DONE ? ld_data : 32'h0;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed self-checking bench for dmem_ctrl
module tb_dmem_ctrl;
  import mem_defs::*;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address, write_data, out_mem;
  logic [1:0]  write_mem;
  logic [2:0]  read_mem;
  logic        mem_stall, misalign, bus_err;
  int          checks = 0;
  int          errors = 0;
  dmem_ctrl_if bus();
  dmem_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .address(address), .write_data(write_data),
    .write_mem(write_mem), .read_mem(read_mem), .out_mem(out_mem),
    .mem_stall(mem_stall), .misalign(misalign), .bus_err(bus_err), .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask
  task automatic load(input string tag, input logic [31:0] a, input logic [2:0] op,
                      input logic [31:0] rd, input logic [31:0] exp);
    address = a; read_mem = op; bus.bus_rdata = rd; bus.bus_ack = 1'b1;
    #1 chk({tag, "_idle_stall"}, mem_stall, 1);
    @(negedge clk);
    chk({tag, "_req"}, bus.bus_req, 1);
    chk({tag, "_addr"}, bus.bus_addr, {a[31:2], 2'b00});
    @(negedge clk);
    chk({tag, "_out"}, out_mem, exp);
    chk({tag, "_done_stall"}, mem_stall, 0);
    read_mem = RM_NONE; bus.bus_ack = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_out"}, out_mem, 0);
  endtask
  task automatic store(input string tag, input logic [31:0] a, input logic [1:0] wm,
                       input logic [31:0] d, input logic [2:0] rm,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd);
    address = a; write_mem = wm; write_data = d; read_mem = rm; bus.bus_ack = 1'b1;
    bus.bus_rdata = 32'hFFFF_FFFF;
    #1 chk({tag, "_idle_stall"}, mem_stall, 1);
    chk({tag, "_idle_req"}, bus.bus_req, 0);
    @(negedge clk);
    chk({tag, "_stall"}, mem_stall, 1);
    chk({tag, "_we"}, bus.bus_we, 1);
    chk({tag, "_be"}, bus.bus_be, exp_be);
    chk({tag, "_wdata"}, bus.bus_wdata, exp_wd);
    chk({tag, "_addr"}, bus.bus_addr, {a[31:2], 2'b00});
    @(negedge clk);
    chk({tag, "_done_stall"}, mem_stall, 0);
    chk({tag, "_done_req"}, bus.bus_req, 0);
    chk({tag, "_done_out"}, out_mem, 0);
    write_mem = WM_NONE; read_mem = RM_NONE; bus.bus_ack = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_be"}, bus.bus_be, 0);
  endtask
  initial begin
    rst = 1'b1; address = 32'h0; write_data = 32'h0; write_mem = WM_NONE; read_mem = RM_NONE;
    bus.bus_ack = 1'b0; bus.bus_rdata = 32'h0;
    @(negedge clk);
    chk("rst_stall", mem_stall, 0);
    chk("rst_req", bus.bus_req, 0);
    chk("rst_out", out_mem, 0);
    chk("rst_err", bus_err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_addr", bus.bus_addr, 0);
    chk("idle_wdata", bus.bus_wdata, 0);
    store("sw", 32'h100, WM_SW, 32'h1234_5678, RM_NONE, 4'b1111, 32'h1234_5678);
    store("sh", 32'h102, WM_SH, 32'h0000_ABCD, RM_NONE, 4'b1100, 32'hABCD_ABCD);
    store("sb", 32'h101, WM_SB, 32'h0000_005A, RM_NONE, 4'b0010, 32'h5A5A_5A5A);
    store("sw_rd", 32'h104, WM_SW, 32'hCAFE_F00D, RM_LW, 4'b1111, 32'hCAFE_F00D);
    load("lb", 32'h103, RM_LB, 32'h80FF_0000, 32'hFFFF_FF80);
    load("lbu", 32'h103, RM_LBU, 32'h80FF_0000, 32'h0000_0080);
    load("lh", 32'h102, RM_LH, 32'h80FF_0000, 32'hFFFF_80FF);
    load("lhu", 32'h102, RM_LHU, 32'h80FF_0000, 32'h0000_80FF);
    load("lb1", 32'h101, RM_LB, 32'h0000_7F00, 32'h0000_007F);
    address = 32'h101; read_mem = RM_LH;
    #1 chk("mis_lh_flag", misalign, 1);
    chk("mis_lh_req", bus.bus_req, 0);
    chk("mis_lh_stall", mem_stall, 0);
    chk("mis_lh_out", out_mem, 0);
    @(negedge clk);
    chk("mis_lh_req2", bus.bus_req, 0);
    read_mem = RM_NONE; address = 32'h102; write_mem = WM_SW;
    #1 chk("mis_sw_flag", misalign, 1);
    chk("mis_sw_stall", mem_stall, 0);
    write_mem = WM_NONE;
    #1 chk("mis_clear", misalign, 0);
    @(negedge clk);
    address = 32'h200; read_mem = RM_LW; bus.bus_rdata = 32'hDEAD_BEEF; bus.bus_ack = 1'b0;
    #1 chk("lw_idle_stall", mem_stall, 1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("lw_wait_stall", mem_stall, 1);
      chk("lw_wait_addr", bus.bus_addr, 32'h200);
      if (i == 5) bus.bus_ack = 1'b1;
    end
    @(negedge clk);
    chk("lw_done_stall", mem_stall, 0);
    chk("lw_done_out", out_mem, 32'hDEAD_BEEF);
    read_mem = RM_NONE; bus.bus_ack = 1'b0;
    @(negedge clk);
    read_mem = RM_LW;
    repeat (3) @(negedge clk);
    chk("rw_wait_req", bus.bus_req, 1);
    rst = 1'b1; bus.bus_ack = 1'b1;
    #1 chk("rw_rst_req", bus.bus_req, 0);
    chk("rw_rst_stall", mem_stall, 0);
    chk("rw_rst_out", out_mem, 0);
    read_mem = RM_NONE;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rw_after_req", bus.bus_req, 0);
    chk("rw_after_out", out_mem, 0);
    bus.bus_ack = 1'b0; address = 32'h300; read_mem = RM_LW;
`ifdef DMEM_TIMEOUT_EN
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("to_wait_stall", mem_stall, 1);
    end
    @(negedge clk);
    chk("to_err", bus_err, 1);
    chk("to_stall", mem_stall, 0);
    chk("to_req", bus.bus_req, 0);
    chk("to_out", out_mem, 0);
    read_mem = RM_NONE;
    @(negedge clk);
    chk("to_err_clear", bus_err, 0);
`else
    repeat (100) @(negedge clk);
    chk("nto_stall", mem_stall, 1);
    chk("nto_req", bus.bus_req, 1);
    chk("nto_err", bus_err, 0);
    rst = 1'b1; read_mem = RM_NONE;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("nto_idle_req", bus.bus_req, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
